alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Keeps the existing 4-bit single-cycle operation set, generalised to WIDTH bits, and registers the result.
- Adds an iterative multiply/divide unit (RV32M-style semantics).
- Sits in the EX stage. The core stalls on in_ready/out_valid instead of assuming a single-cycle result.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount bits taken from datab (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- ctrl  in  5  ctrl[4]=0: base op in ctrl[3:0]; ctrl[4]=1: extended M op
- dataa  in  WIDTH  operand A
- datab  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- aluresult  out  WIDTH  result
- zero  out  1  zero flag
- less  out  1  compare flag
- illegal  out  1  unsupported ctrl encoding was issued

Behaviour:
- Reset (async): state IDLE; out_valid=0, aluresult=0, zero=0, less=0, illegal=0; in_ready=1 after release.
- Reset mid-operation aborts the operation with no output.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept = in_valid & in_ready; operands and ctrl are captured on accept.
- Base op (ctrl[4]=0): compute on accept, register it, go to DONE. out_valid appears 1 cycle after accept.
- Base encodings (? = don't care):
  - 0000 add; 1000 sub.
  - ?001 shl by datab[SHW-1:0]; 0101 lshr; 1101 ashr.
  - 0010 signed less; 1010 unsigned less. Both: result = compare bit zero-extended, less = result, zero = (dataa==datab).
  - ?011 pass datab; ?100 xor; ?110 or; ?111 and.
  - All ops except compares: zero = (result==0), less=0.
- Extended ops (ctrl[4]=1), via ctrl[2:0]:
  - 000 mul (low WIDTH bits); 001 mulh (s×s high); 010 mulhsu (s×u high); 011 mulhu (high).
  - 100 div; 101 divu; 110 rem; 111 remu.
- Extended op timing: on accept go to BUSY. Exactly WIDTH BUSY cycles, one shift-add / restoring-subtract step each on operand magnitudes. Sign fix-up is applied when leaving BUSY; result registered, then DONE.
- Extended op latency: accept to out_valid = WIDTH+1 cycles.
- Extended op flags: zero = (result==0), less=0.
- Divide by zero: div/divu quotient = all ones; rem/remu = dataa. Still takes the full WIDTH cycles.
- Signed overflow (div of most-negative by -1): quotient = most-negative value, remainder = 0.
- DONE: outputs held stable until out_ready. DONE & out_ready leads to IDLE next cycle. A new request is accepted no earlier than the cycle after the handshake, so there is no same-cycle turnaround.
- in_valid while not IDLE is ignored (no capture). Inputs are don't-care except on accept.
- illegal: registered with the result, valid only with out_valid.

Optional Feature:
- Macro ALU_SEQ_MDU_EN.
- Defined: extended ops behave as above; illegal is always 0.
- Undefined: no multiply/divide datapath is built. ctrl[4]=1 completes like a base op (DONE 1 cycle after accept) with aluresult=0, zero=1, less=0, illegal=1. BUSY is unreachable.

Test Plan:
- Reset: hold rst=1 mid-BUSY of a divu -> out_valid=0, aluresult=0 immediately; after release in_ready=1 and no stale result appears.
- Base ops: add 0x7FFFFFFF+1 -> 0x80000000, zero=0, 1-cycle latency. sub 5-5 -> 0, zero=1. ashr 0x80000000 by 4 -> 0xF8000000. slt -1<1 -> result 1, less=1. sltu 0xFFFFFFFF<1 -> 0, zero=0.
- Multiply (MDU_EN): mul 0xFFFFFFFF×2 -> 0xFFFFFFFE. mulh -1×-1 -> 0. mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept.
- Divide corners: div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 10/0 -> 0xFFFFFFFF; remu 10/0 -> 10; div 0x80000000/-1 -> 0x80000000 and rem -> 0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0; in_valid pulses meanwhile are not captured. Handshake cycle -> IDLE; next accept follows.
- Macro off: ctrl=5'b10000 -> after 1 cycle aluresult=0, zero=1, illegal=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU. Single-cycle base operations are registered
// and presented one cycle after accept. The optional iterative multiply/divide
// unit (RV32M-style) is built only when ALU_SEQ_MDU_EN is defined.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready only in IDLE)
//   ctrl[4:0]              ctrl[4]=0 base op ctrl[3:0], ctrl[4]=1 M op ctrl[2:0]
//   dataa, datab           operands, sampled only on accept
//   out_valid / out_ready  result handshake (out_valid only in DONE)
//   aluresult, zero, less  registered result and flags
//   illegal                M op issued while the multiply/divide unit is absent
//
// Macro ALU_SEQ_MDU_EN: build the multiply/divide datapath.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  output logic             less,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             ext_go;
  logic             last_step;
  logic             load;
  logic [WIDTH-1:0] base_res, res_nxt;
  logic             base_zero, base_less;
  logic             zero_nxt, less_nxt, ill_nxt;

  assign accept = in_valid & in_ready;

  // Base operation, evaluated straight from the inputs in the accept cycle
  always_comb begin
    base_res  = '0;
    base_zero = 1'b0;
    base_less = 1'b0;
    case (ctrl[2:0])
      3'b000: base_res = ctrl[3] ? (dataa - datab) : (dataa + datab);
      3'b001: base_res = dataa << datab[SHW-1:0];
      3'b101: base_res = ctrl[3] ? WIDTH'($unsigned($signed(dataa) >>> datab[SHW-1:0]))
                                 : (dataa >> datab[SHW-1:0]);
      3'b010: base_res = ctrl[3] ? WIDTH'(dataa < datab)
                                 : WIDTH'($signed(dataa) < $signed(datab));
      3'b011: base_res = datab;
      3'b100: base_res = dataa ^ datab;
      3'b110: base_res = dataa | datab;
      3'b111: base_res = dataa & datab;
    endcase
    if (ctrl[2:0] == 3'b010) begin
      base_less = base_res[0];
      base_zero = (dataa == datab);
    end else begin
      base_zero = (base_res == '0);
    end
  end

`ifdef ALU_SEQ_MDU_EN
  // Shared iterative datapath: acc:lo is the product (mul) or remainder:quotient (div)
  logic [WIDTH-1:0]   acc, lo, opb;
  logic [WIDTH-1:0]   acc_n, lo_n;
  logic [2:0]         op;
  logic               neg, divz;
  logic [SHW-1:0]     cnt;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, sh;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   mdu_res;

  assign ext_go    = accept & ctrl[4];
  assign last_step = (state == BUSY) && (cnt == SHW'(WIDTH - 1));

  // Operand signedness per op; the iteration always works on magnitudes
  assign a_sgn = dataa[WIDTH-1] & (ctrl[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign b_sgn = datab[WIDTH-1] & (ctrl[2:0] inside {3'b001, 3'b100, 3'b110});
  assign mag_a = a_sgn ? -dataa : dataa;
  assign mag_b = b_sgn ? -datab : datab;

  // One shift-add or restoring-subtract step, then sign fix-up of the outcome
  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    sh   = {acc, lo[WIDTH-1]};
    ge   = (sh >= {1'b0, opb});
    diff = sh[WIDTH-1:0] - opb;
    if (!op[2]) begin
      acc_n = sum[WIDTH:1];
      lo_n  = {sum[0], lo[WIDTH-1:1]};
    end else begin
      acc_n = ge ? diff : sh[WIDTH-1:0];
      lo_n  = {lo[WIDTH-2:0], ge};
    end
    prod   = {acc_n, lo_n};
    prod_s = neg ? -prod : prod;
    if (!op[2]) begin
      mdu_res = (op[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end else if (!op[1]) begin
      // Signed divide by zero must not have its all-ones quotient negated
      mdu_res = divz ? '1 : (neg ? -lo_n : lo_n);
    end else begin
      mdu_res = neg ? -acc_n : acc_n;
    end
  end

  // Iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      lo   <= '0;
      opb  <= '0;
      op   <= '0;
      neg  <= 1'b0;
      divz <= 1'b0;
      cnt  <= '0;
    end else if (ext_go) begin
      acc  <= '0;
      lo   <= mag_a;
      opb  <= mag_b;
      op   <= ctrl[2:0];
      neg  <= (ctrl[2] & ctrl[1]) ? a_sgn : (a_sgn ^ b_sgn);
      divz <= (datab == '0);
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= acc_n;
      lo   <= lo_n;
      cnt  <= cnt + 1'b1;
    end
  end
`else
  assign ext_go    = 1'b0;
  assign last_step = 1'b0;
`endif

  // Result select and load enable
  always_comb begin
    load     = 1'b0;
    res_nxt  = base_res;
    zero_nxt = base_zero;
    less_nxt = base_less;
    ill_nxt  = 1'b0;
    if (accept && !ctrl[4]) begin
      load = 1'b1;
    end
`ifdef ALU_SEQ_MDU_EN
    if (last_step) begin
      load     = 1'b1;
      res_nxt  = mdu_res;
      zero_nxt = (mdu_res == '0);
      less_nxt = 1'b0;
    end
`else
    if (accept && ctrl[4]) begin
      load     = 1'b1;
      res_nxt  = '0;
      zero_nxt = 1'b1;
      less_nxt = 1'b0;
      ill_nxt  = 1'b1;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ext_go ? BUSY : DONE;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluresult <= '0;
      zero      <= 1'b0;
      less      <= 1'b0;
      illegal   <= 1'b0;
    end else if (load) begin
      aluresult <= res_nxt;
      zero      <= zero_nxt;
      less      <= less_nxt;
      illegal   <= ill_nxt;
    end
  end

endmodule
